// File: rtl/kf_frame_loader.sv
// kf_frame_loader: collects a 4-word frame (U0, U1, Y0, Y1) from a word
// stream, commits it atomically to the Kalman core inputs, then holds the
// core clock enable high for STEP_CYCLES cycles so that one update runs.
// A malformed frame raises a one-cycle frame_err and the loader resyncs on
// the next frame marker.
//
// Handshake: a word moves on a rising edge where in_valid and in_ready are
// both high. in_data and in_last are ignored on every other edge. in_ready
// is registered and low only while an update step runs. A source that holds
// in_valid while in_ready is low must keep in_data/in_last stable until the
// word is taken.
module kf_frame_loader #(
    parameter int WIDTH       = 16,
    parameter int STEP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [WIDTH-1:0] U0,
    output logic [WIDTH-1:0] U1,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic             clk_en,
    output logic             busy,
    output logic             frame_err,
    output logic [15:0]      step_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STEP    = 2'd1,
        DROP    = 2'd2
    } state_t;

    // Terminal value of the step counter; the counter starts at 0 on commit.
    localparam logic [7:0] LAST_CNT = 8'(STEP_CYCLES - 1);

    if (STEP_CYCLES < 1 || STEP_CYCLES > 255) begin : g_bad_step_cycles
        $error("kf_frame_loader: STEP_CYCLES must be in 1..255");
    end

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] shadow0_q, shadow1_q, shadow2_q;
    logic             accept;
    logic             shadow_we;
    logic             commit;
    logic             err_d;
    logic             step_done;

    assign accept    = in_valid & in_ready;
    assign busy      = clk_en;
    assign dbg_state = state_q;

    // Next-state logic: word collection, error detection and step timing.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shadow_we = 1'b0;
        commit    = 1'b0;
        err_d     = 1'b0;
        step_done = 1'b0;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (idx_q == 2'd3) begin
                        idx_d = 2'd0;
                        if (in_last) begin
                            commit  = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = STEP;
                        end else begin
                            // Four words without a marker: skip to the next marker.
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (in_last) begin
                        // Early marker closes the short frame; restart at U0.
                        err_d = 1'b1;
                        idx_d = 2'd0;
                    end else begin
                        shadow_we = 1'b1;
                        idx_d     = idx_q + 2'd1;
                    end
                end
            end
            DROP: begin
                if (accept && in_last) begin
                    state_d = COLLECT;
                    idx_d   = 2'd0;
                end
            end
            STEP: begin
                if (cnt_q == LAST_CNT) begin
                    step_done = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = COLLECT;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = COLLECT;
                idx_d   = 2'd0;
            end
        endcase
    end

    // State, index and step counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= COLLECT;
            idx_q   <= 2'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    // Shadow registers hold U0, U1, Y0 until Y1 arrives with the marker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow0_q <= '0;
            shadow1_q <= '0;
            shadow2_q <= '0;
        end else if (shadow_we) begin
            case (idx_q)
                2'd0:    shadow0_q <= in_data;
                2'd1:    shadow1_q <= in_data;
                default: shadow2_q <= in_data;
            endcase
        end
    end

    // Committed frame: all four outputs change together, only on a commit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            U0 <= '0;
            U1 <= '0;
            Y0 <= '0;
            Y1 <= '0;
        end else if (commit) begin
            U0 <= shadow0_q;
            U1 <= shadow1_q;
            Y0 <= shadow2_q;
            Y1 <= in_data;
        end
    end

    // Registered control outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready  <= 1'b0;
            clk_en    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            in_ready  <= (state_d != STEP);
            clk_en    <= (state_d == STEP);
            frame_err <= err_d;
        end
    end

    // Completed-update counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_count <= 16'd0;
        end else if (step_done) begin
            step_count <= step_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_kf_frame_loader.sv
// Bench for kf_frame_loader: a cycle-exact vector table for the first frame,
// the short-frame error and the missing-marker drop case, then hand-written
// sequences for back-to-back frames, reset during a step and counter wrap.
// A monitor compares every committed frame against the expected queue.
module tb_kf_frame_loader;

    localparam int FW = 64;
    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_STEP    = 2'd1;
    localparam logic [1:0] ST_DROP    = 2'd2;
    localparam int STEP_LEN = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        in_ready;
    logic [15:0] U0, U1, Y0, Y1;
    logic        clk_en;
    logic        busy;
    logic        frame_err;
    logic [15:0] step_count;
    logic [1:0]  dbg_state;
    logic [FW-1:0] frame_out;

    assign frame_out = {U0, U1, Y0, Y1};

    kf_frame_loader #(.WIDTH(16), .STEP_CYCLES(STEP_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .U0         (U0),
        .U1         (U1),
        .Y0         (Y0),
        .Y1         (Y1),
        .clk_en     (clk_en),
        .busy       (busy),
        .frame_err  (frame_err),
        .step_count (step_count),
        .dbg_state  (dbg_state)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [FW-1:0] exp_q[$];

    typedef struct {
        logic          vld;
        logic          lst;
        logic [15:0]   dat;
        logic          e_rdy;
        logic          e_en;
        logic          e_err;
        logic [1:0]    e_st;
        logic [FW-1:0] e_frame;
        logic [15:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic vld, input logic lst, input logic [15:0] dat,
                           input logic e_rdy, input logic e_en, input logic e_err,
                           input logic [1:0] e_st, input logic [FW-1:0] e_frame,
                           input logic [15:0] e_cnt);
        vec_t v;
        v.vld = vld; v.lst = lst; v.dat = dat;
        v.e_rdy = e_rdy; v.e_en = e_en; v.e_err = e_err; v.e_st = e_st;
        v.e_frame = e_frame; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Offer one word and hold it until accepted. Called at posedge+1; returns
    // at posedge+1 of the accepting edge, leaving in_valid high.
    task automatic send_word(input logic [15:0] d, input logic l,
                             output int acc_cyc, output logic en_before);
        int   waited;
        logic rdy_now;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        en_before = 1'b0;
        while (1) begin
            rdy_now   = in_ready;
            en_before = clk_en;
            @(posedge clk);
            #1;
            if (rdy_now) break;
            waited++;
            if (waited > 40) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_word timeout: word 0x%0h not accepted in %0d cycles, expected within 40", d, waited);
                break;
            end
        end
        acc_cyc = cyc;
    endtask

    task automatic send_frame(input logic [FW-1:0] f, output int commit_cyc);
        int   c;
        logic e;
        send_word(f[63:48], 1'b0, c, e);
        send_word(f[47:32], 1'b0, c, e);
        send_word(f[31:16], 1'b0, c, e);
        send_word(f[15:0],  1'b1, c, e);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        commit_cyc = c;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while (!(in_ready && !clk_en)) begin
            @(posedge clk);
            #1;
            waited++;
            if (waited > 40) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_idle timeout: in_ready=%0b clk_en=%0b after %0d cycles, expected idle", in_ready, clk_en, waited);
                break;
            end
        end
    endtask

    // Scoreboard: every rising clk_en must match the next expected frame,
    // and every completed run of clk_en must last exactly STEP_LEN cycles.
    int   run = 0;
    logic en_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            run     = 0;
            en_prev = 1'b0;
        end else begin
            if (clk_en && !en_prev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected commit: frame 0x%0h, expected no commit", frame_out);
                end else begin
                    check("commit frame", frame_out, exp_q.pop_front());
                end
                run = 1;
            end else if (clk_en) begin
                run++;
            end else if (en_prev) begin
                check("clk_en run length", FW'(run), FW'(STEP_LEN));
            end
            check("busy equals clk_en", FW'(busy), FW'(clk_en));
            en_prev = clk_en;
        end
    end

    initial begin
        #100000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    localparam logic [FW-1:0] F0 = 64'h0000_0000_0000_0000;
    localparam logic [FW-1:0] F1 = 64'h0001_0002_0003_0004;
    localparam logic [FW-1:0] FA = 64'hAAAA_BBBB_CCCC_DDDD;
    localparam logic [FW-1:0] FB = 64'h1111_2222_3333_4444;

    initial begin
        int   c1, c2a, c2, ctmp;
        logic en_b;

        // ---------------- vector table ----------------
        // Each row: inputs for one cycle, outputs expected after its edge.
        add_vec(1, 0, 16'h0001, 1, 0, 0, ST_COLLECT, F0, 16'd0); // in_ready still 0: not taken
        add_vec(1, 0, 16'h0001, 1, 0, 0, ST_COLLECT, F0, 16'd0);
        add_vec(1, 0, 16'h0002, 1, 0, 0, ST_COLLECT, F0, 16'd0);
        add_vec(1, 0, 16'h0003, 1, 0, 0, ST_COLLECT, F0, 16'd0);
        add_vec(1, 1, 16'h0004, 0, 1, 0, ST_STEP,    F1, 16'd0); // commit
        for (int k = 0; k < STEP_LEN - 1; k++)
            add_vec(1, 1, 16'h00FF, 0, 1, 0, ST_STEP, F1, 16'd0); // offered but refused
        add_vec(1, 1, 16'h00FF, 1, 0, 0, ST_COLLECT, F1, 16'd1);  // step ends, still refused
        add_vec(0, 0, 16'h0000, 1, 0, 0, ST_COLLECT, F1, 16'd1);
        // Marker on the 2nd word, then a good frame.
        add_vec(1, 0, 16'h0011, 1, 0, 0, ST_COLLECT, F1, 16'd1);
        add_vec(1, 1, 16'h0012, 1, 0, 1, ST_COLLECT, F1, 16'd1);
        add_vec(1, 0, 16'hAAAA, 1, 0, 0, ST_COLLECT, F1, 16'd1);
        add_vec(1, 0, 16'hBBBB, 1, 0, 0, ST_COLLECT, F1, 16'd1);
        add_vec(1, 0, 16'hCCCC, 1, 0, 0, ST_COLLECT, F1, 16'd1);
        add_vec(1, 1, 16'hDDDD, 0, 1, 0, ST_STEP,    FA, 16'd1);
        for (int k = 0; k < STEP_LEN - 1; k++)
            add_vec(0, 0, 16'h0000, 0, 1, 0, ST_STEP, FA, 16'd1);
        add_vec(0, 0, 16'h0000, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        // Four words with no marker, junk until marker, then a good frame.
        add_vec(1, 0, 16'h0101, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h0102, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h0103, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h0104, 1, 0, 1, ST_DROP,    FA, 16'd2);
        add_vec(1, 0, 16'h0201, 1, 0, 0, ST_DROP,    FA, 16'd2);
        add_vec(1, 0, 16'h0202, 1, 0, 0, ST_DROP,    FA, 16'd2);
        add_vec(1, 1, 16'h0203, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h1111, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h2222, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 0, 16'h3333, 1, 0, 0, ST_COLLECT, FA, 16'd2);
        add_vec(1, 1, 16'h4444, 0, 1, 0, ST_STEP,    FB, 16'd2);
        for (int k = 0; k < STEP_LEN - 1; k++)
            add_vec(0, 0, 16'h0000, 0, 1, 0, ST_STEP, FB, 16'd2);
        add_vec(0, 0, 16'h0000, 1, 0, 0, ST_COLLECT, FB, 16'd3);

        exp_q.push_back(F1);
        exp_q.push_back(FA);
        exp_q.push_back(FB);

        // ---------------- reset state ----------------
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",   FW'(in_ready),   FW'(0));
        check("reset clk_en",     FW'(clk_en),     FW'(0));
        check("reset frame_err",  FW'(frame_err),  FW'(0));
        check("reset frame",      frame_out,       F0);
        check("reset step_count", FW'(step_count), FW'(0));
        check("reset state",      FW'(dbg_state),  FW'(ST_COLLECT));
        #3 reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid = vecs[i].vld;
            in_last  = vecs[i].lst;
            in_data  = vecs[i].dat;
            @(posedge clk);
            #1;
            check($sformatf("row%0d in_ready", i),   FW'(in_ready),   FW'(vecs[i].e_rdy));
            check($sformatf("row%0d clk_en", i),     FW'(clk_en),     FW'(vecs[i].e_en));
            check($sformatf("row%0d frame_err", i),  FW'(frame_err),  FW'(vecs[i].e_err));
            check($sformatf("row%0d state", i),      FW'(dbg_state),  FW'(vecs[i].e_st));
            check($sformatf("row%0d frame", i),      frame_out,       vecs[i].e_frame);
            check($sformatf("row%0d step_count", i), FW'(step_count), FW'(vecs[i].e_cnt));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // ---------------- back-to-back frames ----------------
        exp_q.push_back(64'h1234_5678_9ABC_DEF0);
        exp_q.push_back(64'hFFFF_0000_8001_7FFE);
        send_word(16'h1234, 1'b0, ctmp, en_b);
        send_word(16'h5678, 1'b0, ctmp, en_b);
        send_word(16'h9ABC, 1'b0, ctmp, en_b);
        send_word(16'hDEF0, 1'b1, c1, en_b);
        send_word(16'hFFFF, 1'b0, c2a, en_b);
        check("b2b first word clk_en before accept", FW'(en_b), FW'(0));
        check("b2b first word latency", FW'(c2a - c1), FW'(STEP_LEN + 1));
        send_word(16'h0000, 1'b0, ctmp, en_b);
        send_word(16'h8001, 1'b0, ctmp, en_b);
        check("b2b outputs held before commit", frame_out, 64'h1234_5678_9ABC_DEF0);
        send_word(16'h7FFE, 1'b1, c2, en_b);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("b2b frame period", FW'(c2 - c1), FW'(4 + STEP_LEN));
        check("b2b second commit", frame_out, 64'hFFFF_0000_8001_7FFE);
        wait_idle();
        check("b2b step_count", FW'(step_count), FW'(5));

        // ---------------- reset during a step ----------------
        exp_q.push_back(64'h0A0A_0B0B_0C0C_0D0D);
        send_frame(64'h0A0A_0B0B_0C0C_0D0D, ctmp);
        @(posedge clk);
        @(posedge clk);
        #2;
        check("mid-step clk_en before reset", FW'(clk_en), FW'(1));
        reset = 1'b0;
        #1;
        check("mid-step reset clk_en",     FW'(clk_en),     FW'(0));
        check("mid-step reset busy",       FW'(busy),       FW'(0));
        check("mid-step reset in_ready",   FW'(in_ready),   FW'(0));
        check("mid-step reset frame",      frame_out,       F0);
        check("mid-step reset step_count", FW'(step_count), FW'(0));
        check("mid-step reset state",      FW'(dbg_state),  FW'(ST_COLLECT));
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset in_ready", FW'(in_ready), FW'(1));
        exp_q.push_back(64'h5555_6666_7777_8888);
        send_frame(64'h5555_6666_7777_8888, ctmp);
        check("post-reset commit", frame_out, 64'h5555_6666_7777_8888);
        wait_idle();
        check("post-reset step_count", FW'(step_count), FW'(1));

        // ---------------- step_count wrap ----------------
        force dut.step_count = 16'hFFFF;
        #1;
        release dut.step_count;
        check("wrap preload", FW'(step_count), FW'(16'hFFFF));
        exp_q.push_back(64'h0001_FFFF_8000_7FFF);
        send_frame(64'h0001_FFFF_8000_7FFF, ctmp);
        wait_idle();
        check("wrap step_count", FW'(step_count), FW'(0));

        repeat (2) @(posedge clk);
        #1;
        check("all expected commits seen", FW'(exp_q.size()), FW'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/kf_frame_loader.md
Name: kf_frame_loader

Overview:
- Upstream feeder for the Kalman filter core.
- Accepts a 16-bit word stream over a valid/ready handshake and assembles each 4-word frame in order U0, U1, Y0, Y1.
- Commits a complete frame atomically to the core's U0/U1/Y0/Y1 inputs, then drives the core's clk_en for a fixed number of cycles so one filter update runs.
- Detects malformed frames and resynchronises on the next frame marker.

Parameters:
- WIDTH, 16, sample word width; matches core U/Y width.
- STEP_CYCLES, 8, clk_en-high cycles per filter update; legal range 1..255 (elaboration error outside).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_data  input  WIDTH  sample word.
- in_valid  input  1  in_data valid.
- in_last  input  1  frame marker; must be high on the 4th word (Y1) only.
- in_ready  output  1  loader can accept a word this cycle.
- U0, U1, Y0, Y1  output  WIDTH each  committed frame to the core.
- clk_en  output  1  core clock enable (registered).
- busy  output  1  high while an update step is running (equals clk_en).
- frame_err  output  1  one-cycle pulse on a malformed frame.
- step_count  output  16  completed updates; wraps 0xFFFF->0x0000.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs 0, including in_ready, clk_en and frame_err.
  - State = COLLECT, word index = 0, shadow registers = 0.
  - Asserting reset during STEP drops clk_en immediately (asynchronously). No partial step is counted.
- After reset deassertion: in_ready=1 from the first clock edge onward (registered).
- Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1. in_data/in_last are ignored otherwise.
- States: COLLECT, STEP, DROP. in_ready is 1 in COLLECT and DROP, 0 in STEP.
- COLLECT:
  - Accepted word goes to shadow[idx]; idx increments.
  - idx 0..2 with in_last=0: normal; stay in COLLECT.
  - idx 0..2 with in_last=1: frame_err=1 next cycle; discard shadow; idx=0; stay in COLLECT (the marker closes the bad frame).
  - idx 3 with in_last=1: commit. On the same edge, U0/U1/Y0/Y1 load from shadow[0..2] and in_data; state->STEP; clk_en=1; idx=0.
  - idx 3 with in_last=0: frame_err=1 next cycle; discard; state->DROP.
- DROP: accept and discard words until one with in_last=1 is accepted, then go to COLLECT with idx=0. No further frame_err pulses while in DROP.
- STEP:
  - Counter runs; clk_en=1 for exactly STEP_CYCLES consecutive cycles, starting the cycle after the commit handshake.
  - On the last one, the edge clears clk_en, increments step_count and returns to COLLECT. in_ready=1 in the same cycle that clk_en=0.
- U0..Y1 change only at commit. They are stable throughout STEP and until the next commit; a bad frame never disturbs them.
- Minimum frame period: 4 + STEP_CYCLES cycles with continuous in_valid.
- in_valid held high while in_ready=0: no acceptance. The word is taken once in_ready returns; the source must hold data stable.
- frame_err and a commit never occur on the same edge; each error is a single-cycle pulse.
- No arithmetic on the data path: words pass through bit-exact.

Test Plan:
- Reset then frame 0x0001,0x0002,0x0003,0x0004 (last on 4th), back-to-back valid -> U0..Y1 = 1,2,3,4 on the cycle after 4th handshake; clk_en high 8 cycles; in_ready low those 8 cycles; step_count=1.
- Two frames back-to-back with in_valid held high -> 2nd frame's 1st word accepted in the cycle clk_en falls; outputs switch only at the 2nd commit; step_count=2; frame period 12 cycles.
- Frame with in_last on the 2nd word, then a good frame 0xAAAA,0xBBBB,0xCCCC,0xDDDD -> one frame_err pulse; outputs unchanged until the good commit, then AAAA..DDDD; no extra clk_en.
- Frame of 4 words with no in_last, then 3 junk words with last on the 3rd, then a good frame -> one frame_err; junk discarded in DROP; good frame commits correctly.
- Assert reset on the 3rd clk_en cycle -> clk_en drops asynchronously; all outputs 0; step_count=0; next frame after release commits normally.
- Preload step_count to 0xFFFF via 65535 frames (or STEP_CYCLES=1 fast sim), then 1 more -> step_count wraps to 0x0000.
